mux_scan: RTL and testbench

Parametrised, registered N-channel multiplexer and the successor to the combinational 8x1 mux. It is generalised in channel count and data width, registers its output with a valid flag, and adds an auto-scan mode. In auto-scan mode an internal sequencer steps through all channels, holding each one for a programmable dwell time. It sits between multi-channel sources and a single-lane consumer, such as a monitor, serialiser or test probe.

---
 rtl/mux_scan.sv | 139 +++++++++++++
 tb/tb_mux_scan.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - registered N-channel mux with optional auto-scan sequencer
// Scan mode (SCAN state, scan/dwell counters, wrap pulse) is built only when SCAN_MODE_EN is defined.
module mux_scan #(
  parameter  int N_CH  = 8,
  parameter  int DW    = 1,
  parameter  int DWELL = 4,
  localparam int SW    = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SW-1:0]      sel,
  input  logic [N_CH*DW-1:0] din,
  output logic [DW-1:0]      dout,
  output logic               dout_vld,
  output logic [SW-1:0]      cur_sel,
  output logic               wrap
);

  localparam logic [SW:0] N_CH_W = (SW+1)'(N_CH);

`ifdef SCAN_MODE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MANUAL = 2'd1, SCAN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MANUAL = 2'd1} state_t;
`endif

  state_t state, state_nx;

  logic [DW-1:0] ch_data [N_CH];
  logic [DW-1:0] dout_nx;
  logic          vld_nx;
  logic [SW-1:0] cur_nx;
  logic          sel_ok;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ch_data[k] = din[k*DW +: DW];
  end

  // Only reachable when N_CH is not a power of two.
  assign sel_ok = ({1'b0, sel} < N_CH_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = IDLE;
    if (en) begin
`ifdef SCAN_MODE_EN
      state_nx = mode ? SCAN : MANUAL;
`else
      state_nx = MANUAL;
`endif
    end
  end

`ifdef SCAN_MODE_EN
  localparam int            DCW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0] LAST_DW = DCW'(DWELL - 1);
  localparam logic [SW-1:0]  LAST_CH = SW'(N_CH - 1);

  logic [SW-1:0]  scan_ch, scan_ch_nx;
  logic [DCW-1:0] dwell_cnt, dwell_nx;
  logic           wrap_q, wrap_nx;

  // Any cycle not continuing a scan leaves the position at channel 0, so re-entry starts fresh.
  always_comb begin
    scan_ch_nx = '0;
    dwell_nx   = '0;
    wrap_nx    = 1'b0;
    if (state_nx == SCAN && state == SCAN) begin
      if (dwell_cnt == LAST_DW) begin
        scan_ch_nx = (scan_ch == LAST_CH) ? '0 : scan_ch + 1'b1;
        wrap_nx    = (scan_ch == LAST_CH);
      end else begin
        scan_ch_nx = scan_ch;
        dwell_nx   = dwell_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_ch   <= '0;
      dwell_cnt <= '0;
      wrap_q    <= 1'b0;
    end else begin
      scan_ch   <= scan_ch_nx;
      dwell_cnt <= dwell_nx;
      wrap_q    <= wrap_nx;
    end
  end

  assign wrap = wrap_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{mode, DWELL[0]};
  assign wrap       = 1'b0;
`endif

  always_comb begin
    dout_nx = '0;
    vld_nx  = 1'b0;
    cur_nx  = cur_sel;
    case (state_nx)
      MANUAL: begin
        cur_nx = sel;
        if (sel_ok) begin
          dout_nx = ch_data[sel];
          vld_nx  = 1'b1;
        end
      end
`ifdef SCAN_MODE_EN
      SCAN: begin
        cur_nx  = scan_ch_nx;
        dout_nx = ch_data[scan_ch_nx];
        vld_nx  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      cur_sel  <= '0;
    end else begin
      dout     <= dout_nx;
      dout_vld <= vld_nx;
      cur_sel  <= cur_nx;
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// tb/tb_mux_scan.sv - randomized bench for mux_scan against a cycle-count reference model
// Follows SCAN_MODE_EN the same way the design does.
module tb_mux_scan;

  logic        clk = 1'b0;
  logic        rst_n, en, mode;
  logic [2:0]  sel;
  logic [31:0] din;
  logic [3:0]  dout0, dout1;
  logic        vld0, vld1, wrap0, wrap1;
  logic [2:0]  cur0, cur1;

  always #5 clk = ~clk;

  mux_scan #(.N_CH(8), .DW(4), .DWELL(4)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .din(din),
    .dout(dout0), .dout_vld(vld0), .cur_sel(cur0), .wrap(wrap0)
  );

  mux_scan #(.N_CH(6), .DW(4), .DWELL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .din(din[23:0]),
    .dout(dout1), .dout_vld(vld1), .cur_sel(cur1), .wrap(wrap1)
  );

`ifdef SCAN_MODE_EN
  localparam bit SCAN_ON = 1'b1;
`else
  localparam bit SCAN_ON = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  int         nch [2] = '{8, 6};
  int         dwl [2] = '{4, 1};
  int         m_t   [2];
  logic [3:0] m_dout[2];
  logic       m_vld [2];
  logic       m_wrap[2];
  int         m_cur [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [3:0] chan(input int k);
    return din[k*4 +: 4];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_t[i] = -1; m_dout[i] = '0; m_vld[i] = 1'b0; m_wrap[i] = 1'b0; m_cur[i] = 0;
    end
  endtask

  // Scan position is the number of cycles since entry; channel and wrap follow by division.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!en) begin
        m_t[i] = -1; m_dout[i] = '0; m_vld[i] = 1'b0; m_wrap[i] = 1'b0;
      end else if (mode && SCAN_ON) begin
        int ch;
        m_t[i]    = (m_t[i] < 0) ? 0 : m_t[i] + 1;
        ch        = (m_t[i] / dwl[i]) % nch[i];
        m_dout[i] = chan(ch);
        m_cur[i]  = ch;
        m_vld[i]  = 1'b1;
        m_wrap[i] = (m_t[i] > 0) && (m_t[i] % (nch[i] * dwl[i]) == 0);
      end else begin
        m_t[i]    = -1;
        m_wrap[i] = 1'b0;
        m_cur[i]  = int'(sel);
        if (int'(sel) < nch[i]) begin
          m_dout[i] = chan(int'(sel)); m_vld[i] = 1'b1;
        end else begin
          m_dout[i] = '0; m_vld[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".dout0"}, 32'(dout0), 32'(m_dout[0]));
    check({ctx, ".vld0"},  32'(vld0),  32'(m_vld[0]));
    check({ctx, ".cur0"},  32'(cur0),  32'(m_cur[0]));
    check({ctx, ".wrap0"}, 32'(wrap0), 32'(m_wrap[0]));
    check({ctx, ".dout1"}, 32'(dout1), 32'(m_dout[1]));
    check({ctx, ".vld1"},  32'(vld1),  32'(m_vld[1]));
    check({ctx, ".cur1"},  32'(cur1),  32'(m_cur[1]));
    check({ctx, ".wrap1"}, 32'(wrap1), 32'(m_wrap[1]));
  endtask

  // Called at a falling edge: drive, let one rising edge pass, compare on the next falling edge.
  task automatic step(input string ctx, input logic e, input logic m, input logic [2:0] s,
                      input logic [31:0] d);
    en = e; mode = m; sel = s; din = d;
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare_all(ctx);
  endtask

  logic [31:0] ramp;
  logic        rmode;

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; din = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;

    ramp = '0;
    for (int k = 0; k < 8; k++) ramp[k*4 +: 4] = 4'(k + 3);
    for (int s = 0; s < 8; s++) step("manual", 1'b1, 1'b0, 3'(s), ramp);
    step("en_gate", 1'b0, 1'b0, 3'd2, ramp);

    for (int c = 0; c < 40; c++) step("scan", 1'b1, 1'b1, 3'd6, (c < 20) ? ramp : $urandom);

    step("idle", 1'b0, 1'b1, 3'd0, ramp);
    for (int c = 0; c < 13; c++) step("scan2", 1'b1, 1'b1, 3'd1, ramp);
    step("mode_sw", 1'b1, 1'b0, 3'd5, ramp);
    for (int c = 0; c < 6; c++) step("reenter", 1'b1, 1'b1, 3'd5, ramp);

    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all("async_rst");
    @(negedge clk);
    compare_all("rst_hold");
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) step("post_rst", 1'b1, 1'b1, 3'd7, $urandom);

    rmode = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 39) == 0) rmode = ~rmode;
      step("rand", $urandom_range(0, 29) != 0, rmode, 3'($urandom_range(0, 7)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
